// File: rtl/ttl_counter_cascade.sv
// Cascaded 4-bit synchronous counter stages (binary or BCD, up/down) with
// 74163-style clear/load, ENP/ENT enables, per-digit carries and ripple carry.
module ttl_counter_cascade #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BCD    = 0
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  ce,
  input  logic                  _clear,
  input  logic                  _load,
  input  logic                  enp,
  input  logic                  ent,
  input  logic                  up,
  input  logic [4*DIGITS-1:0]   d,
  output logic [4*DIGITS-1:0]   q,
  output logic [DIGITS-1:0]     dc,
  output logic                  rco
);

  localparam int unsigned W   = 4 * DIGITS;
  localparam logic [3:0]  TOP = (BCD != 0) ? 4'd9 : 4'd15;

  logic [W-1:0] q_next;

  // Invalid BCD nibbles 10..14 step normally and 15 wraps to 0 via 4-bit overflow.
  function automatic logic [3:0] digit_inc(input logic [3:0] v);
    if ((BCD != 0) && (v == 4'd9)) return 4'd0;
    return v + 4'd1;
  endfunction

  function automatic logic [3:0] digit_dec(input logic [3:0] v);
    if ((BCD != 0) && (v == 4'd0)) return 4'd9;
    return v - 4'd1;
  endfunction

  // Carry chain: a digit advances only while every digit below it sits at terminal.
  always_comb begin : carry_chain
    logic       adv;
    logic       term;
    logic [3:0] dig;
    adv    = 1'b1;
    term   = 1'b0;
    dig    = 4'd0;
    q_next = q;
    dc     = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      dig  = q[4*k +: 4];
      term = up ? (dig == TOP) : (dig == 4'd0);
      if (adv) q_next[4*k +: 4] = up ? digit_inc(dig) : digit_dec(dig);
      adv   = adv & term;
      dc[k] = ent & adv;
    end
  end

  assign rco = dc[DIGITS-1];

  // Count register: clear > load > count > hold, all qualified by ce.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      q <= '0;
    end else if (ce) begin
      if (!_clear)          q <= '0;
      else if (!_load)      q <= d;
      else if (enp && ent)  q <= q_next;
    end
  end

endmodule

// File: tb/tb_ttl_counter_cascade.sv
// Bench for ttl_counter_cascade: integer/decimal reference model checked every
// cycle, plus directed literal expectations for reset, wrap, BCD and cascading.
module tb_ttl_counter_cascade;

  logic       clk = 1'b0;
  logic       rst_l, ce, clr_l, ld_l, enp, ent, up;
  logic [7:0] d;
  logic       c_ce, c_ld_l, c_en, c_up;
  logic [7:0] c_d;

  logic [7:0] b2_q, d2_q, r_q;
  logic [1:0] b2_dc, d2_dc, r_dc;
  logic [3:0] d1_q, lo_q, hi_q;
  logic       d1_dc, lo_dc, hi_dc;
  logic       b2_rco, d2_rco, d1_rco, lo_rco, hi_rco, r_rco;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mb, md, mc;
  logic [3:0] m1;

  always #5 clk = ~clk;

  ttl_counter_cascade #(.DIGITS(2), .BCD(0)) u_b2 (
    .clk(clk), ._reset(rst_l), .ce(ce), ._clear(clr_l), ._load(ld_l), .enp(enp),
    .ent(ent), .up(up), .d(d), .q(b2_q), .dc(b2_dc), .rco(b2_rco));
  ttl_counter_cascade #(.DIGITS(2), .BCD(1)) u_d2 (
    .clk(clk), ._reset(rst_l), .ce(ce), ._clear(clr_l), ._load(ld_l), .enp(enp),
    .ent(ent), .up(up), .d(d), .q(d2_q), .dc(d2_dc), .rco(d2_rco));
  ttl_counter_cascade #(.DIGITS(1), .BCD(1)) u_d1 (
    .clk(clk), ._reset(rst_l), .ce(ce), ._clear(clr_l), ._load(ld_l), .enp(enp),
    .ent(ent), .up(up), .d(d[3:0]), .q(d1_q), .dc(d1_dc), .rco(d1_rco));
  ttl_counter_cascade #(.DIGITS(1), .BCD(0)) u_lo (
    .clk(clk), ._reset(rst_l), .ce(c_ce), ._clear(1'b1), ._load(c_ld_l), .enp(c_en),
    .ent(c_en), .up(c_up), .d(c_d[3:0]), .q(lo_q), .dc(lo_dc), .rco(lo_rco));
  ttl_counter_cascade #(.DIGITS(1), .BCD(0)) u_hi (
    .clk(clk), ._reset(rst_l), .ce(c_ce), ._clear(1'b1), ._load(c_ld_l), .enp(lo_rco),
    .ent(1'b1), .up(c_up), .d(c_d[7:4]), .q(hi_q), .dc(hi_dc), .rco(hi_rco));
  ttl_counter_cascade #(.DIGITS(2), .BCD(0)) u_ref (
    .clk(clk), ._reset(rst_l), .ce(c_ce), ._clear(1'b1), ._load(c_ld_l), .enp(c_en),
    .ent(c_en), .up(c_up), .d(c_d), .q(r_q), .dc(r_dc), .rco(r_rco));

  // BCD step: decimal arithmetic when every digit is valid, digit rules otherwise.
  function automatic logic [7:0] m_bcd_next(input logic [7:0] v, input logic u, input int nd);
    logic [7:0] r;
    logic [3:0] dig;
    bit   valid, carry, term;
    int   dec, p;
    valid = 1'b1; dec = 0; p = 1; r = v;
    for (int k = 0; k < nd; k++) begin
      dig = v[4*k +: 4];
      if (dig > 4'd9) valid = 1'b0;
      dec += int'(dig) * p;
      p *= 10;
    end
    if (valid) begin
      dec = u ? (dec + 1) % p : (dec + p - 1) % p;
      r = '0;
      for (int k = 0; k < nd; k++) begin
        r[4*k +: 4] = 4'(dec % 10);
        dec = dec / 10;
      end
    end else begin
      carry = 1'b1;
      for (int k = 0; k < nd; k++) begin
        if (carry) begin
          dig  = v[4*k +: 4];
          term = u ? (dig == 4'd9) : (dig == 4'd0);
          r[4*k +: 4] = u ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1)
                          : ((dig == 4'd0) ? 4'd9 : dig - 4'd1);
          carry = term;
        end
      end
    end
    return r;
  endfunction

  // dc[k]: the low k+1 digits equal the all-terminal pattern for the direction.
  function automatic logic [7:0] m_dc(input logic [31:0] v, input logic u, input logic e,
                                      input int nd, input bit bcd);
    logic [31:0] mask, pat;
    logic [7:0]  r;
    r   = '0;
    pat = u ? (bcd ? 32'h9999_9999 : 32'hFFFF_FFFF) : 32'h0;
    for (int k = 0; k < nd; k++) begin
      mask = (32'h1 << (4 * (k + 1))) - 32'h1;
      r[k] = e && ((v & mask) == (pat & mask));
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mb <= '0; md <= '0; m1 <= '0;
    end else if (ce) begin
      if (!clr_l) begin
        mb <= '0; md <= '0; m1 <= '0;
      end else if (!ld_l) begin
        mb <= d; md <= d; m1 <= d[3:0];
      end else if (enp && ent) begin
        mb <= up ? mb + 8'd1 : mb - 8'd1;
        md <= m_bcd_next(md, up, 2);
        m1 <= 4'(m_bcd_next(8'(m1), up, 1));
      end
    end
  end

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l)        mc <= '0;
    else if (c_ce) begin
      if (!c_ld_l)     mc <= c_d;
      else if (c_en)   mc <= c_up ? mc + 8'd1 : mc - 8'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [7:0] e;
    e = m_dc(32'(mb), up, ent, 2, 1'b0);
    chk("b2_q", 32'(b2_q), 32'(mb));
    chk("b2_dc", 32'(b2_dc), 32'(e[1:0]));
    chk("b2_rco", 32'(b2_rco), 32'(e[1]));
    e = m_dc(32'(md), up, ent, 2, 1'b1);
    chk("d2_q", 32'(d2_q), 32'(md));
    chk("d2_dc", 32'(d2_dc), 32'(e[1:0]));
    chk("d2_rco", 32'(d2_rco), 32'(e[1]));
    e = m_dc(32'(m1), up, ent, 1, 1'b1);
    chk("d1_q", 32'(d1_q), 32'(m1));
    chk("d1_rco", 32'(d1_rco), 32'(e[0]));
    chk("d1_dc", 32'(d1_dc), 32'(e[0]));
    e = m_dc(32'(mc), c_up, c_en, 2, 1'b0);
    chk("casc_q", 32'({hi_q, lo_q}), 32'(mc));
    chk("ref_q", 32'(r_q), 32'(mc));
    chk("ref_dc", 32'(r_dc), 32'(e[1:0]));
    chk("ref_rco", 32'(r_rco), 32'(e[1]));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_inv [4];
    exp_inv = '{4'hD, 4'hE, 4'hF, 4'h0};
    rst_l = 1'b0; ce = 1'b1; clr_l = 1'b1; ld_l = 1'b1; enp = 1'b0; ent = 1'b0; up = 1'b1; d = '0;
    c_ce = 1'b1; c_ld_l = 1'b1; c_en = 1'b0; c_up = 1'b1; c_d = '0;

    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    // Reset state and reset-time carry.
    step(2);
    chk("reset_q", 32'(b2_q), 32'h00);
    chk("reset_rco_up", 32'(b2_rco), 32'h0);
    ent = 1'b1; up = 1'b0; #1;
    chk("reset_rco_down", 32'(b2_rco), 32'h1);
    ent = 1'b0; up = 1'b1;
    step(1);
    rst_l = 1'b1;

    // Async reset mid-count at 0x37.
    ld_l = 1'b0; d = 8'h35; step(1);
    ld_l = 1'b1; enp = 1'b1; ent = 1'b1; step(2);
    chk("count_to_37", 32'(b2_q), 32'h37);
    enp = 1'b0; ent = 1'b0;
    #1 rst_l = 1'b0;
    #1 chk("async_reset", 32'(b2_q), 32'h00);
    #1 rst_l = 1'b1;
    step(1);

    // Clear beats load.
    clr_l = 1'b0; ld_l = 1'b0; d = 8'hA5; step(1);
    chk("clear_wins", 32'(b2_q), 32'h00);
    clr_l = 1'b1; ld_l = 1'b1;

    // Binary up wrap.
    ld_l = 1'b0; d = 8'hFE; enp = 1'b1; ent = 1'b1; up = 1'b1; step(1);
    ld_l = 1'b1; step(1);
    chk("bin_ff", 32'(b2_q), 32'hFF);
    chk("bin_ff_rco", 32'(b2_rco), 32'h1);
    step(1);
    chk("bin_wrap", 32'(b2_q), 32'h00);
    chk("bin_wrap_rco", 32'(b2_rco), 32'h0);
    ld_l = 1'b0; d = 8'hFF; step(1);
    ld_l = 1'b1; enp = 1'b0; #1;
    chk("ff_rco_ent1", 32'(b2_rco), 32'h1);
    ent = 1'b0; #1;
    chk("ff_rco_ent0", 32'(b2_rco), 32'h0);
    step(1);

    // BCD up then down.
    ld_l = 1'b0; d = 8'h98; enp = 1'b1; ent = 1'b1; up = 1'b1; step(1);
    ld_l = 1'b1; step(1);
    chk("bcd_99", 32'(d2_q), 32'h99);
    chk("bcd_99_rco", 32'(d2_rco), 32'h1);
    step(1);
    chk("bcd_wrap", 32'(d2_q), 32'h00);
    up = 1'b0; #1;
    chk("bcd_down_rco", 32'(d2_rco), 32'h1);
    step(1);
    chk("bcd_down_wrap", 32'(d2_q), 32'h99);
    ld_l = 1'b0; d = 8'h10; step(1);
    ld_l = 1'b1; step(1);
    chk("bcd_10_down", 32'(d2_q), 32'h09);

    // BCD invalid nibble on a single digit.
    ld_l = 1'b0; d = 8'h0C; up = 1'b1; step(1);
    ld_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("inv_q", 32'(d1_q), 32'(exp_inv[i]));
      chk("inv_rco", 32'(d1_rco), 32'h0);
    end
    step(9);
    chk("inv_to_9", 32'(d1_q), 32'h9);
    chk("inv_9_rco", 32'(d1_rco), 32'h1);

    // Enables and clock enable.
    ld_l = 1'b0; d = 8'h10; enp = 1'b0; ent = 1'b1; step(1);
    ld_l = 1'b1; step(5);
    chk("enp_hold", 32'(b2_q), 32'h10);
    ce = 1'b0; ld_l = 1'b0; d = 8'h55; step(1);
    chk("ce_blocks_load", 32'(b2_q), 32'h10);
    ld_l = 1'b1; enp = 1'b1; ent = 1'b1; up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ce = (i % 2 == 0);
      step(1);
    end
    chk("ce_toggle", 32'(b2_q), 32'h15);
    ce = 1'b1;
    for (int i = 0; i < 24; i++) begin
      up  = 1'($urandom_range(0, 1));
      enp = ($urandom_range(0, 3) != 0);
      step(1);
    end
    enp = 1'b0; ent = 1'b0; up = 1'b1;

    // Cascade: two single-digit stages against a two-digit instance.
    c_ld_l = 1'b0; c_d = 8'h0F; c_en = 1'b1; c_up = 1'b1; step(1);
    c_ld_l = 1'b1; #1;
    chk("casc_lo_rco", 32'(lo_rco), 32'h1);
    step(1);
    chk("casc_hi_inc", 32'(hi_q), 32'h1);
    chk("casc_lo_wrap", 32'(lo_q), 32'h0);
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 25) c_up = ~c_up;
      c_ce = ($urandom_range(0, 3) != 0);
      step(1);
    end
    c_ce = 1'b1; c_en = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
